// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue/result bundle between the execute stage and the HI/LO multiply-divide unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             w_start;
    logic             w_flush;
    logic [5:0]       w_op_code_6;
    logic [WIDTH-1:0] w_input1_x;
    logic [WIDTH-1:0] w_input2_x;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_output_x;
    logic [WIDTH-1:0] w_hi_x;
    logic [WIDTH-1:0] w_lo_x;

    modport master (
        output w_start, w_flush, w_op_code_6, w_input1_x, w_input2_x,
        input  w_busy, w_done, w_output_x, w_hi_x, w_lo_x
    );

    modport slave (
        input  w_start, w_flush, w_op_code_6, w_input1_x, w_input2_x,
        output w_busy, w_done, w_output_x, w_hi_x, w_lo_x
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; MULDIV_MTHILO_EN adds MTHI/MTLO writes
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic         clock,
    input logic         reset_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [5:0] OP_MFHI = 6'h10;
    localparam logic [5:0] OP_MFLO = 6'h12;
`ifdef MULDIV_MTHILO_EN
    localparam logic [5:0] OP_MTHI = 6'h11;
    localparam logic [5:0] OP_MTLO = 6'h13;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic               done_q, done_d;

    logic               is_arith, sgn, neg1, neg2;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     mul_sum, trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   quo, rem;

    assign is_arith = bus.w_op_code_6[5:2] == 4'b0110;
    assign sgn      = !bus.w_op_code_6[0];
    assign neg1     = sgn && bus.w_input1_x[WIDTH-1];
    assign neg2     = sgn && bus.w_input2_x[WIDTH-1];
    assign abs1     = neg1 ? -bus.w_input1_x : bus.w_input1_x;
    assign abs2     = neg2 ? -bus.w_input2_x : bus.w_input2_x;

    // Shift-add multiply keeps the multiplier in the low half; restoring divide builds the quotient there
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign trial    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
    assign div_next = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Sign correction; a zero divisor leaves |dividend| as remainder, so re-signing it restores the dividend
    assign prod = neg_res_q ? -acc_q : acc_q;
    assign quo  = div0_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Next-state, iteration and HI/LO update logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        m_d       = m_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        if (state_q == IDLE) begin
            if (bus.w_start && !bus.w_flush) begin
                if (is_arith) begin
                    state_d   = RUN;
                    cnt_d     = CW'(WIDTH);
                    is_div_d  = bus.w_op_code_6[1];
                    neg_res_d = neg1 ^ neg2;
                    neg_rem_d = neg1;
                    div0_d    = bus.w_input2_x == '0;
                    acc_d     = bus.w_op_code_6[1] ? {{WIDTH{1'b0}}, abs1} : {{WIDTH{1'b0}}, abs2};
                    m_d       = bus.w_op_code_6[1] ? abs2 : abs1;
                end
`ifdef MULDIV_MTHILO_EN
                else if (bus.w_op_code_6 == OP_MTHI) begin
                    hi_d   = bus.w_input1_x;
                    done_d = 1'b1;
                end else if (bus.w_op_code_6 == OP_MTLO) begin
                    lo_d   = bus.w_input1_x;
                    done_d = 1'b1;
                end
`endif
            end
        end else if (bus.w_flush) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            acc_d   = is_div_q ? div_next : mul_next;
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == CW'(1) ? FIX : RUN;
        end else begin
            hi_d    = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
            lo_d    = is_div_q ? quo : prod[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset aborts any operation at once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
        end
    end

    assign bus.w_busy     = state_q != IDLE;
    assign bus.w_done     = done_q;
    assign bus.w_hi_x     = hi_q;
    assign bus.w_lo_x     = lo_q;
    assign bus.w_output_x = bus.w_op_code_6 == OP_MFHI ? hi_q :
                            bus.w_op_code_6 == OP_MFLO ? lo_q : '0;
endmodule
